// File: rtl/bsg_idiv_unsigned_recip_pipe_pkg.sv
// Shared types and width helpers for the reciprocal-multiply unsigned divider.
package bsg_idiv_recip_pkg;

    // Divisor-configuration FSM states
    typedef enum logic [1:0] {
        eIdle,
        eInit,
        eCalc,
        eDone
    } cfg_state_e;

    // Shift constant is ceil(log2 d) for d < 2^D, so it never exceeds D
    function automatic int recip_shift_width(input int denom_width);
        return $clog2(denom_width + 1);
    endfunction

    // Multiply constant lies in [2^N, 2^(N+1)), so it needs N+1 bits
    function automatic int recip_multiply_width(input int numer_width);
        return numer_width + 1;
    endfunction

endpackage

// File: rtl/bsg_idiv_unsigned_recip_pipe_cfg_calc.sv
// Divisor configuration engine: latches a raw divisor, finds its shift,
// derives ceil(2^(s+N)/d) with a bit-serial restoring divider and publishes
// the constants used by the streaming datapath.
module bsg_idiv_recip_cfg_calc
    import bsg_idiv_recip_pkg::*;
#(
    parameter int numer_width_p    = 32,
    parameter int denom_width_p    = 32,
    parameter int shift_width_p    = recip_shift_width(denom_width_p),
    parameter int multiply_width_p = recip_multiply_width(numer_width_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        cfg_v_i,
    input  logic [denom_width_p-1:0]    cfg_denom_i,
    output logic                        cfg_ready_o,
    output logic [denom_width_p-1:0]    divisor_o,
    output logic [shift_width_p-1:0]    shift_o,
    output logic [multiply_width_p-1:0] multiply_o,
    output logic                        zero_o
);

    localparam int D  = denom_width_p;
    localparam int SW = shift_width_p;
    localparam int MW = multiply_width_p;
    localparam int CW = $clog2(numer_width_p + 1);

    cfg_state_e    state_q;
    logic [D-1:0]  d_q;
    logic [SW-1:0] s_q;
    logic          zero_pend_q;
    logic [D:0]    r_q;
    logic [MW-1:0] q_q;
    logic [CW-1:0] cnt_q;

    logic [D-1:0]  divisor_q;
    logic [SW-1:0] shift_q;
    logic [MW-1:0] multiply_q;
    logic          zero_q;

    logic [D-1:0]  dm1;
    logic [SW-1:0] s_d;
    logic [D:0]    r_shl;
    logic [D:0]    r_sub;
    logic          r_ge;

    // Shift encoder: ceil(log2 d) is one past the top set bit of d-1 (0 for d=1)
    always_comb begin
        dm1 = cfg_denom_i - D'(1);
        s_d = '0;
        for (int i = 0; i < D; i++) begin
            if (dm1[i]) s_d = SW'(i + 1);
        end
    end

    // One restoring-division step; r < d always, so doubling fits in D+1 bits
    always_comb begin
        r_shl = r_q << 1;
        r_ge  = (r_shl >= {1'b0, d_q});
        r_sub = r_shl - {1'b0, d_q};
    end

    // Config FSM with the published constant registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= eIdle;
            zero_pend_q <= 1'b0;
            divisor_q   <= D'(1);
            shift_q     <= '0;
            multiply_q  <= MW'(1) << numer_width_p;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                eIdle: begin
                    if (cfg_v_i) begin
                        d_q         <= cfg_denom_i;
                        s_q         <= s_d;
                        zero_pend_q <= (cfg_denom_i == '0);
                        state_q     <= (cfg_denom_i == '0) ? eDone : eInit;
                    end
                end
                eInit: begin
                    // Leading quotient bit is always 1 since 2^(s-1) < d <= 2^s;
                    // it is shifted up into bit N over the following N steps.
                    q_q     <= MW'(1);
                    r_q     <= ((D + 1)'(1) << s_q) - {1'b0, d_q};
                    cnt_q   <= CW'(numer_width_p - 1);
                    state_q <= eCalc;
                end
                eCalc: begin
                    q_q <= {q_q[MW-2:0], r_ge};
                    r_q <= r_ge ? r_sub : r_shl;
                    if (cnt_q == '0) begin
                        state_q <= eDone;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                eDone: begin
                    if (zero_pend_q) begin
                        divisor_q  <= '0;
                        shift_q    <= '0;
                        multiply_q <= MW'(1) << numer_width_p;
                        zero_q     <= 1'b1;
                    end else begin
                        // Round up: a nonzero remainder means the quotient was truncated
                        divisor_q  <= d_q;
                        shift_q    <= s_q;
                        multiply_q <= q_q + MW'(r_q != '0);
                        zero_q     <= 1'b0;
                    end
                    state_q <= eIdle;
                end
                default: state_q <= eIdle;
            endcase
        end
    end

    assign cfg_ready_o = (state_q == eIdle);
    assign divisor_o   = divisor_q;
    assign shift_o     = shift_q;
    assign multiply_o  = multiply_q;
    assign zero_o      = zero_q;

endmodule

// File: rtl/bsg_idiv_unsigned_recip_pipe.sv
// Two-stage streaming unsigned divider: x/d and x%d via multiply by a
// precomputed reciprocal. Constants ride along with each operand so a
// reconfiguration never disturbs results already in flight.
module bsg_idiv_unsigned_recip_pipe
    import bsg_idiv_recip_pkg::*;
#(
    parameter int numer_width_p    = 32,
    parameter int denom_width_p    = 32,
    parameter int shift_width_p    = recip_shift_width(denom_width_p),
    parameter int multiply_width_p = recip_multiply_width(numer_width_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cfg_v_i,
    input  logic [denom_width_p-1:0] cfg_denom_i,
    output logic                     cfg_ready_o,
    input  logic                     v_i,
    input  logic [numer_width_p-1:0] numer_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [numer_width_p-1:0] quotient_o,
    output logic [numer_width_p-1:0] remainder_o,
    input  logic                     ready_i
);

    localparam int N  = numer_width_p;
    localparam int D  = denom_width_p;
    localparam int SW = shift_width_p;
    localparam int MW = multiply_width_p;
    localparam int PW = MW + N;

    // Divide-by-zero saturates the quotient to all ones
    function automatic logic [N-1:0] sat_quot(input logic zero, input logic [N-1:0] q);
        return zero ? '1 : q;
    endfunction

    // Divide-by-zero leaves the numerator as the remainder
    function automatic logic [N-1:0] sat_rem(input logic zero, input logic [N-1:0] numer,
                                             input logic [N-1:0] r);
        return zero ? numer : r;
    endfunction

    logic [D-1:0]  cfg_div;
    logic [SW-1:0] cfg_shift;
    logic [MW-1:0] cfg_mult;
    logic          cfg_zero;

    bsg_idiv_recip_cfg_calc #(
        .numer_width_p   (numer_width_p),
        .denom_width_p   (denom_width_p),
        .shift_width_p   (shift_width_p),
        .multiply_width_p(multiply_width_p)
    ) u_cfg (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .cfg_v_i    (cfg_v_i),
        .cfg_denom_i(cfg_denom_i),
        .cfg_ready_o(cfg_ready_o),
        .divisor_o  (cfg_div),
        .shift_o    (cfg_shift),
        .multiply_o (cfg_mult),
        .zero_o     (cfg_zero)
    );

    logic          vld_p1_q, vld_p2_q;
    logic          adv_p1, adv_p2, in_fire;

    logic [PW-1:0] prod_p1_q;
    logic [N-1:0]  numer_p1_q;
    logic [D-1:0]  div_p1_q;
    logic [SW-1:0] shift_p1_q;
    logic          zero_p1_q;

    logic [PW-1:0] prod_d;
    logic [MW-1:0] hi_d;
    logic [N-1:0]  quot_d, rem_d;

    logic [N-1:0]  quot_p2_q, rem_p2_q;

    assign adv_p2  = ~vld_p2_q | ready_i;
    assign adv_p1  = ~vld_p1_q | adv_p2;
    assign ready_o = cfg_ready_o & adv_p1;
    assign in_fire = v_i & ready_o;

    // Stage 1 inputs: full-width reciprocal product
    assign prod_d = PW'(cfg_mult) * PW'(numer_i);

    // Stage 2 inputs: scale the product down, then back-multiply for the remainder
    always_comb begin
        hi_d   = MW'(prod_p1_q >> N);
        quot_d = N'(hi_d >> shift_p1_q);
        rem_d  = numer_p1_q - quot_d * N'(div_p1_q);
    end

    // Pipeline valids
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            if (adv_p1) vld_p1_q <= in_fire;
            if (adv_p2) vld_p2_q <= vld_p1_q;
        end
    end

    // ---- stage 1: product and the constants this operand was accepted under ----
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            prod_p1_q  <= prod_d;
            numer_p1_q <= numer_i;
            div_p1_q   <= cfg_div;
            shift_p1_q <= cfg_shift;
            zero_p1_q  <= cfg_zero;
        end
    end

    // ---- stage 2: quotient and remainder, held while the consumer stalls ----
    always_ff @(posedge clk_i) begin
        if (adv_p2 && vld_p1_q) begin
            quot_p2_q <= sat_quot(zero_p1_q, quot_d);
            rem_p2_q  <= sat_rem(zero_p1_q, numer_p1_q, rem_d);
        end
    end

    assign v_o         = vld_p2_q;
    assign quotient_o  = quot_p2_q;
    assign remainder_o = rem_p2_q;

endmodule

// File: tb/tb_bsg_idiv_unsigned_recip_pipe.sv
module tb_bsg_idiv_unsigned_recip_pipe;

    localparam int N = 8;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         cfg_v_i;
    logic [D-1:0] cfg_denom_i;
    logic         cfg_ready_o;
    logic         v_i;
    logic [N-1:0] numer_i;
    logic         ready_o;
    logic         v_o;
    logic [N-1:0] quotient_o;
    logic [N-1:0] remainder_o;
    logic         ready_i;

    always #5 clk = ~clk;

    bsg_idiv_unsigned_recip_pipe #(
        .numer_width_p(N),
        .denom_width_p(D)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .cfg_v_i    (cfg_v_i),
        .cfg_denom_i(cfg_denom_i),
        .cfg_ready_o(cfg_ready_o),
        .v_i        (v_i),
        .numer_i    (numer_i),
        .ready_o    (ready_o),
        .v_o        (v_o),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o),
        .ready_i    (ready_i)
    );

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention
    function automatic void ref_div(input int n, input int d, output int q, output int r);
        if (d == 0) begin
            q = (1 << N) - 1;
            r = n;
        end else begin
            q = n / d;
            r = n % d;
        end
    endfunction

    // Scoreboard state
    int   exp_q[$];
    int   exp_r[$];
    int   seen_q[$];
    int   seen_r[$];
    int   cur_d = 1;
    bit   prev_stall = 1'b0;
    int   prev_q, prev_r;

    // Compare process: sampled on the falling edge, ahead of the next rising edge
    always @(negedge clk) begin
        int eq, er;
        if (reset_i) begin
            exp_q.delete();
            exp_r.delete();
            cur_d      = 1;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_v", int'(v_o), 1);
                check("hold_q", int'(quotient_o), prev_q);
                check("hold_r", int'(remainder_o), prev_r);
            end
            if (v_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got q=%0d r=%0d, expected none", quotient_o, remainder_o);
                end else begin
                    eq = exp_q.pop_front();
                    er = exp_r.pop_front();
                    check("res_q", int'(quotient_o), eq);
                    check("res_r", int'(remainder_o), er);
                    seen_q.push_back(int'(quotient_o));
                    seen_r.push_back(int'(remainder_o));
                end
            end
            prev_stall = v_o && !ready_i;
            prev_q     = int'(quotient_o);
            prev_r     = int'(remainder_o);
            // A numerator accepted alongside a new divisor still sees the old one
            if (v_i && ready_o) begin
                ref_div(int'(numer_i), cur_d, eq, er);
                exp_q.push_back(eq);
                exp_r.push_back(er);
            end
            if (cfg_v_i && cfg_ready_o) cur_d = int'(cfg_denom_i);
        end
    end

    // Consumer backpressure generator
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_cfg(input int d, input int exp_busy);
        int n;
        cfg_denom_i = D'(d);
        cfg_v_i     = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg_ready_o && n < 200);
        @(posedge clk);
        #1;
        cfg_v_i = 1'b0;
        n = 1;
        while (!cfg_ready_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("cfg_busy_d%0d", d), n, exp_busy);
    endtask

    task automatic send(input int x);
        int n;
        numer_i = N'(x);
        v_i     = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_o && n < 200);
        if (!ready_o) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    task automatic send_expect(input int x, input int eq, input int er);
        int c;
        send(x);
        c = 1;
        while (!v_o && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        check($sformatf("latency_%0d", x), c, 2);
        check($sformatf("dir_q_%0d", x), int'(quotient_o), eq);
        check($sformatf("dir_r_%0d", x), int'(remainder_o), er);
    endtask

    task automatic check_consts(input int s, input int m);
        check("shift_const", int'(dut.u_cfg.shift_o), s);
        check("mult_const", int'(dut.u_cfg.multiply_o), m);
    endtask

    initial begin
        int d, n, sel;
        reset_i     = 1'b1;
        cfg_v_i     = 1'b0;
        cfg_denom_i = '0;
        v_i         = 1'b0;
        numer_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;

        check("rst_cfg_ready", int'(cfg_ready_o), 1);
        check("rst_v_o", int'(v_o), 0);
        check("rst_ready_o", int'(ready_o), 1);
        check_consts(0, 256);

        send_expect(200, 200, 0);

        do_cfg(3, 11);
        check_consts(2, 342);
        send_expect(200, 66, 2);

        do_cfg(7, 11);
        check_consts(3, 293);
        send_expect(255, 36, 3);

        do_cfg(255, 11);
        check_consts(8, 258);
        send_expect(254, 0, 254);
        send_expect(255, 1, 0);

        do_cfg(0, 2);
        send_expect(77, 255, 77);

        do_cfg(1, 11);
        check_consts(0, 256);
        send_expect(255, 255, 0);

        // Back-to-back numerators with a reconfiguration on the last one
        do_cfg(3, 11);
        seen_q.delete();
        seen_r.delete();
        v_i = 1'b1;
        numer_i = 8'd10;
        @(negedge clk);
        check("b2b_ready0", int'(ready_o), 1);
        @(posedge clk);
        #1;
        numer_i = 8'd11;
        @(negedge clk);
        check("b2b_ready1", int'(ready_o), 1);
        @(posedge clk);
        #1;
        numer_i     = 8'd12;
        cfg_v_i     = 1'b1;
        cfg_denom_i = 8'd5;
        @(negedge clk);
        check("b2b_ready2", int'(ready_o), 1);
        check("b2b_cfg_ready", int'(cfg_ready_o), 1);
        @(posedge clk);
        #1;
        v_i     = 1'b0;
        cfg_v_i = 1'b0;
        n = 1;
        while (!cfg_ready_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_cfg_busy", n, 11);
        check("b2b_count", seen_q.size(), 3);
        if (seen_q.size() == 3) begin
            check("b2b_q0", seen_q[0], 3);
            check("b2b_r0", seen_r[0], 1);
            check("b2b_q1", seen_q[1], 3);
            check("b2b_r1", seen_r[1], 2);
            check("b2b_q2", seen_q[2], 4);
            check("b2b_r2", seen_r[2], 0);
        end
        send_expect(12, 2, 2);

        // Randomized traffic with consumer backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                sel = int'($urandom_range(0, 7));
                case (sel)
                    0:       d = 0;
                    1:       d = 1;
                    2:       d = 255;
                    3:       d = 1 << $urandom_range(1, 7);
                    default: d = int'($urandom_range(2, 254));
                endcase
                do_cfg(d, (d == 0) ? 2 : 11);
            end
            send(int'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);

        // Reset while the divider is iterating
        do_cfg(1, 11);
        cfg_denom_i = 8'd3;
        cfg_v_i     = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        cfg_v_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_calc_busy", int'(cfg_ready_o), 0);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        check("post_rst_cfg_ready", int'(cfg_ready_o), 1);
        check_consts(0, 256);
        send_expect(200, 200, 0);
        repeat (3) @(posedge clk);
        #1;
        check("final_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bsg_idiv_unsigned_recip_pipe.md
Name: bsg_idiv_unsigned_recip_pipe

Overview:
Pipelined unsigned divider by an infrequently changing divisor, with quotient and remainder outputs.
- Owns its divisor configuration: takes a raw divisor and computes the shift/multiply constants itself with an iterative FSM.
- Streams numerators through a 2-stage valid/ready pipeline at one result per cycle.
- Sits in address-hash and stride-generation paths that need x/d and x%d without a full iterative divider.

Parameters:
numer_width_p, 32, numerator width N (also quotient and remainder width).
denom_width_p, 32, divisor width D; require 1 <= D <= N.
shift_width_p, `bsg_idiv_unsigned_recip_shift_width(denom_width_p), width of shift constant.
multiply_width_p, `bsg_idiv_unsigned_recip_multiply_width(numer_width_p), width of multiply constant (N+1).

Ports:
clk_i  in  1  clock; single clock domain.
reset_i  in  1  synchronous, active-high reset.
cfg_v_i  in  1  new divisor valid.
cfg_denom_i  in  D  new divisor value.
cfg_ready_o  out  1  config FSM idle; cfg accepted when cfg_v_i & cfg_ready_o.
v_i  in  1  numerator valid.
numer_i  in  N  numerator.
ready_o  out  1  numerator accepted when v_i & ready_o.
v_o  out  1  result valid.
quotient_o  out  N  floor(numer / d); all-ones if d==0.
remainder_o  out  N  numer - quotient*d; numer if d==0.
ready_i  in  1  consumer ready (ready-and); result consumed when v_o & ready_i.

Behaviour:
- Reset: cfg_ready_o=1; v_o=0; pipeline valids cleared.
- Reset divisor state: divisor 1, shift 0, multiply 2^N, zero-flag 0, so quotient = numerator.
- Reset mid-computation aborts the FSM and restores the reset divisor state.
- Config FSM states:
  - eIdle: cfg_ready_o=1. On accept, latch d and compute s = ceil(log2 d) combinationally (d=1 gives 0).
    - d==0: go to eDone with zero-flag set.
    - otherwise: go to eInit.
  - eInit: q[N]=1, r = 2^s - d (D+1 bits), cnt=N-1.
  - eCalc (N cycles): r = 2r; if r >= d then q[cnt]=1 and r -= d; cnt-- each cycle.
  - eDone: multiply = q + (r != 0), i.e. the ceiling of 2^(s+N)/d. Write divisor, shift, multiply and zero-flag registers; return to eIdle.
- Busy time from acceptance (cycle 0): d != 0 gives cfg_ready_o=1 again at cycle N+3; d==0 gives it at cycle 2.
- ready_o = (FSM in eIdle) & stage1 can advance.
- A numerator accepted in the same cycle as a cfg accept uses the old constants.
- Stage 1 captures into its register:
  - product = multiply * numer (2N+1 bits)
  - numer, divisor, shift, zero-flag.
- Constants travel with the data, so in-flight operations complete under the constants they entered with, even if config changes.
- Stage 2 captures:
  - q = product[2N:N] >> shift, truncated to N bits.
  - rem = numer - q*divisor, N bits.
  - If zero-flag: q = all-ones and rem = numer.
- Latency: accept at cycle t gives v_o at t+2 if not stalled. Throughput is 1 per cycle.
- Each stage advances when it is empty or the next stage advances. Stage 2 drains on ready_i.
- Under backpressure, outputs hold stable and no data is dropped or duplicated.
- Config accept is independent of pipeline occupancy.

Decomposition:
- Widths come from the existing bsg_idiv_unsigned_recip.svh macros.
- Package bsg_idiv_recip_pkg holds the FSM state enum (eIdle, eInit, eCalc, eDone).
- One sub-module: bsg_idiv_recip_cfg_calc (FSM, shift encoder, restoring divider, constant registers).
- The datapath stays in the top module.

Test Plan:
- Reset, no cfg, N=D=8: numer 200 -> q=200, rem=0, v_o 2 cycles after accept.
- cfg d=3 -> cfg_ready_o low for 10 cycles; internal shift=2, multiply=342. Then numer 200 -> q=66, rem=2.
- cfg d=7 (shift=3, multiply=293): numer 255 -> q=36, rem=3. cfg d=255 (multiply=258): numer 254 -> q=0, rem=254; numer 255 -> q=1, rem=0.
- cfg d=0 -> cfg_ready_o returns at cycle 2; numer 77 -> q=255, rem=77. cfg d=1 -> numer 255 -> q=255, rem=0.
- Back-to-back numerators 10,11,12 with d=3 in flight, then cfg d=5 accepted the same cycle as 12 -> results 3r1, 3r2, 4r0. Next numerator after ready_o rises, 12 -> 2r2.
- Random ready_i toggling over 1000 random numer/d pairs -> order preserved, every result matches the reference model, outputs stable while v_o & ~ready_i.
- Assert reset during eCalc -> cfg_ready_o=1 next cycle, divide-by-1 behaviour restored.
